// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants shared across the UART blocks: arbiter states,
//               byte width and the baud divider for 27 MHz / 115200.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t S_IDLE = 2'd0;
    localparam arb_state_t S_SEND = 2'd1;
    localparam arb_state_t S_LOCK = 2'd2;

    localparam int BYTE_W   = 8;
    localparam int BAUD_DIV = 234;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_picker
// Description : Combinational round-robin picker. Selects the first set request
//               at or after i_ptr, wrapping NUM_REQ-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int   w_idx;
    logic w_found;

    // Walk offsets from the pointer; explicit subtract keeps non-power-of-two counts correct.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_idx          = PTR_W'(w_idx);
                o_grant[w_idx] = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule : uart_rr_picker
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter byte port among
//               NUM_REQ requesters. Optional packet locking: UART_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0]    i_req_data,
    input  logic [NUM_REQ-1:0]           i_req_last,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_tx_valid,
    output logic [BYTE_W-1:0]            o_tx_data,
    input  logic                         i_tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                         o_busy
);

    localparam int               PTR_W      = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(NUM_REQ - 1);

    arb_state_t          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant_id;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_tx_valid;

    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [PTR_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [PTR_W-1:0]    w_next_ptr;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_next_ptr = (r_grant_id == C_LAST_IDX) ? '0 : r_grant_id + PTR_W'(1);

`ifdef UART_ARB_LOCK_EN
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic            r_last;
    logic [BC_W-1:0] r_burst_cnt;
    logic            w_lock_xfer;
    logic            w_release;

    assign w_lock_xfer = (r_state == S_LOCK) && i_req_valid[r_grant_id];
    assign w_release   = r_last || (r_burst_cnt == BC_W'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b0;
            r_burst_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_pick_any) begin
            r_last      <= i_req_last[w_pick_idx];
            r_burst_cnt <= BC_W'(1);
        end else if (w_lock_xfer) begin
            r_last      <= i_req_last[r_grant_id];
            r_burst_cnt <= r_burst_cnt + BC_W'(1);
        end
    end
`else
    logic        w_unused_last;
    logic [31:0] w_unused_cfg;

    assign w_unused_last = ^i_req_last;
    assign w_unused_cfg  = 32'(MAX_BURST);
`endif

    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE) begin
            o_req_ready = w_pick_grant;
        end
`ifdef UART_ARB_LOCK_EN
        else if (r_state == S_LOCK) begin
            o_req_ready[r_grant_id] = i_req_valid[r_grant_id];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_tx_data  <= i_req_data[{w_pick_idx, 3'b000} +: BYTE_W];
                        r_grant_id <= w_pick_idx;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
`ifdef UART_ARB_LOCK_EN
                        if (w_release) begin
                            r_ptr   <= w_next_ptr;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_LOCK;
                        end
`else
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef UART_ARB_LOCK_EN
                S_LOCK: begin
                    // Other requesters wait here until the owner finishes its packet.
                    if (w_lock_xfer) begin
                        r_tx_data  <= i_req_data[{r_grant_id, 3'b000} +: BYTE_W];
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
`endif
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state != S_IDLE);

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (4 requesters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  dat [4];
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int total;
    int bad;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_grant_id  (grant_id),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Accept edge then handshake edge, with tx_ready held high by the caller.
    task automatic xfer(input string tag, input logic [1:0] gid, input logic [7:0] data);
        tick();
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_data"},  32'(tx_data),  32'(data));
        check({tag, "_gid"},   32'(grant_id), 32'(gid));
        tick();
    endtask

    initial begin
        int ord [5] = '{0, 1, 2, 3, 0};
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;

        do_reset();
        check("rst_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'h00);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant",     32'(grant_id),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // Single requester 1
        tx_ready  = 1'b1;
        dat[1]    = 8'hA5;
        req_valid = 4'b0010;
        #1;
        check("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        check("single_valid", 32'(tx_valid),  32'd1);
        check("single_data",  32'(tx_data),   32'hA5);
        check("single_gid",   32'(grant_id),  32'd1);
        check("single_busy",  32'(busy),      32'd1);
        check("single_rdy0",  32'(req_ready), 32'd0);
        tick();
        check("single_done_valid", 32'(tx_valid), 32'd0);
        check("single_done_busy",  32'(busy),     32'd0);

        // Round robin with all requesters valid
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
        req_valid = 4'b1111;
        tx_ready  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << ord[n]));
            xfer("rr", 2'(ord[n]), 8'h10 + 8'(ord[n]));
        end
        req_valid = 4'b0000;

        // Back-pressure: requester 2 held for 10 cycles, ptr now 1
        tx_ready  = 1'b0;
        dat[2]    = 8'h3C;
        req_valid = 4'b0100;
        #1;
        check("bp_accept_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            check("bp_valid", 32'(tx_valid),  32'd1);
            check("bp_data",  32'(tx_data),   32'h3C);
            check("bp_gid",   32'(grant_id),  32'd2);
            check("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(tx_valid),  32'd0);
        check("bp_wrap_ready", 32'(req_ready), 32'b0001);
        tick();
        check("bp_next_valid", 32'(tx_valid), 32'd1);
        check("bp_next_gid",   32'(grant_id), 32'd0);
        check("bp_next_data",  32'(tx_data),  32'h10);
        req_valid = 4'b0000;
        tick();
        check("bp_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of S_SEND
        tx_ready  = 1'b0;
        dat[3]    = 8'h77;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        check("mid_valid", 32'(tx_valid), 32'd1);
        check("mid_gid",   32'(grant_id), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),     32'd0);
        check("mid_rst_data",  32'(tx_data),  32'h00);
        check("mid_rst_gid",   32'(grant_id), 32'd0);
        tick();
        rst_n     = 1'b1;
        tx_ready  = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("mid_after_ready", 32'(req_ready), 32'b0001);
        xfer("mid_after", 2'd0, 8'h10);
        req_valid = 4'b0000;

`ifdef UART_ARB_LOCK_EN
        // Packet from requester 2 must not be interleaved with requester 0
        do_reset();
        tx_ready  = 1'b1;
        dat[2]    = 8'h01;
        req_last  = 4'b0000;
        req_valid = 4'b0100;
        xfer("lk_b1", 2'd2, 8'h01);
        dat[0]    = 8'hAA;
        dat[2]    = 8'h02;
        req_valid = 4'b0101;
        #1;
        check("lk_ready", 32'(req_ready), 32'b0100);
        xfer("lk_b2", 2'd2, 8'h02);
        dat[2]    = 8'h03;
        req_last  = 4'b0100;
        xfer("lk_b3", 2'd2, 8'h03);
        req_last  = 4'b0000;
        req_valid = 4'b0001;
        xfer("lk_r0", 2'd0, 8'hAA);
        req_valid = 4'b0000;

        // Burst limit of 4 forces release to requester 3
        do_reset();
        dat[3]    = 8'h3F;
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            dat[1] = 8'h21 + 8'(n);
            xfer("mb_r1a", 2'd1, 8'h21 + 8'(n));
        end
        dat[1] = 8'h25;
        xfer("mb_r3", 2'd3, 8'h3F);
        req_valid = 4'b0010;
        xfer("mb_r1b", 2'd1, 8'h25);
        dat[1] = 8'h26;
        xfer("mb_r1c", 2'd1, 8'h26);
        req_valid = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
